lm_sequencer: RTL and testbench

Multi-cycle load-multiple (LM) engine for the memory stage of the pipelined RISC15 core. It reads consecutive data-memory words and writes each one into the register named by the set bits of the LM immediate mask. It is the read-side counterpart of the store-data forwarding path used by SW/SM. While it works, it holds the front of the pipeline stalled.

---
 rtl/lm_sequencer_pkg.sv | 17 +
 rtl/lm_prio_enc.sv | 19 +
 rtl/lm_sequencer.sv | 132 +++++++++++++
 tb/tb_lm_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lm_sequencer_pkg.sv
// rtl/lm_sequencer_pkg.sv - shared RISC15 core constants and the LM sequencer state type
package lm_sequencer_pkg;

    // Major opcodes, op[5:2]
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lm_state_e;

endpackage

// File: rtl/lm_prio_enc.sv
// rtl/lm_prio_enc.sv - 8-to-3 lowest-set-bit priority encoder with valid flag
module lm_prio_enc (
    input  logic [7:0] i_mask,
    output logic [2:0] o_idx,
    output logic       o_valid
);

    // Scan from the top down so the lowest set bit has the final say
    always_comb begin
        o_idx   = 3'd0;
        o_valid = |i_mask;
        for (int i = 7; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/lm_sequencer.sv
// rtl/lm_sequencer.sv - load-multiple engine for the mem stage; LM_SEQ_FWD_EN adds a registered forwarding copy of each write
module lm_sequencer
    import lm_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        reg_mask,
    input  logic              kill,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_wr_en,
    output logic [2:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              busy,
    output logic              done
`ifdef LM_SEQ_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [2:0]        fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    lm_state_e         r_state;
    logic [7:0]        r_mask;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_pend_reg;
    logic              r_pend_valid;
    logic              r_done;

    logic [2:0]        w_idx;
    logic              w_idx_valid;
    logic [7:0]        w_mask_clr;

    lm_prio_enc u_prio_enc (
        .i_mask  (r_mask),
        .o_idx   (w_idx),
        .o_valid (w_idx_valid)
    );

    assign w_mask_clr = r_mask & ~(8'd1 << w_idx);

    // Sequencer FSM: latch the request, issue one read per cycle, retire after the last write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mask       <= 8'd0;
            r_addr       <= '0;
            r_pend_reg   <= 3'd0;
            r_pend_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_pend_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !kill) begin
                        r_addr <= base_addr;
                        r_mask <= reg_mask;
                        if (reg_mask == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // A killed read is still on the bus but never gets a write-back slot
                    if (kill || !w_idx_valid) begin
                        r_state <= ST_IDLE;
                        r_mask  <= 8'd0;
                    end else begin
                        r_mask       <= w_mask_clr;
                        r_addr       <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_pend_reg   <= w_idx;
                        r_pend_valid <= 1'b1;
                        if (w_mask_clr == 8'd0) begin
                            r_state <= ST_DRAIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en  = (r_state == ST_RUN);
    assign mem_addr   = mem_rd_en ? r_addr : '0;
    assign rf_wr_en   = r_pend_valid;
    assign rf_wr_addr = r_pend_valid ? r_pend_reg : 3'd0;
    assign rf_wr_data = r_pend_valid ? mem_rdata : '0;
    // A flush landing on the retire cycle suppresses the done pulse
    assign done       = r_done & ~(kill & (r_state == ST_DRAIN));
    // Combinational so the front end freezes in the same cycle LM shows up
    assign busy       = (r_state != ST_IDLE) | (start & ~kill);

`ifdef LM_SEQ_FWD_EN
    logic              r_fwd_valid;
    logic [2:0]        r_fwd_reg;
    logic [DATA_W-1:0] r_fwd_data;

    // One-cycle-delayed copy of the register-file write for the operand bypass
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_reg   <= 3'd0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= rf_wr_en;
            r_fwd_reg   <= rf_wr_addr;
            r_fwd_data  <= rf_wr_data;
        end
    end

    assign fwd_valid = r_fwd_valid;
    assign fwd_reg   = r_fwd_reg;
    assign fwd_data  = r_fwd_data;
`endif

endmodule

// File: tb/tb_lm_sequencer.sv
// tb/tb_lm_sequencer.sv - directed vector bench for lm_sequencer
module tb_lm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        busy;
    logic        done;
`ifdef LM_SEQ_FWD_EN
    logic        fwd_valid;
    logic [2:0]  fwd_reg;
    logic [15:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lm_sequencer #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .reg_mask   (reg_mask),
        .kill       (kill),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .busy       (busy),
        .done       (done)
`ifdef LM_SEQ_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data)
`endif
    );

    // Data memory: two fixed words, otherwise address xor C3C3, one-cycle read latency
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0040) return 16'hAAAA;
        if (a == 16'h0041) return 16'hBBBB;
        return a ^ 16'hC3C3;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_word(mem_addr);
    end

    typedef struct {
        logic        rst, st, kl;
        logic [15:0] base;
        logic [7:0]  mask;
        logic        rd;
        logic [15:0] addr;
        logic        wr;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        bsy, dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, st, kl, input logic [15:0] base, input logic [7:0] mask,
                                input logic rd, input logic [15:0] addr, input logic wr, input logic [2:0] wa,
                                input logic [15:0] wd, input logic bsy, dn);
        vec_t v;
        v.rst = rst; v.st = st; v.kl = kl; v.base = base; v.mask = mask;
        v.rd = rd; v.addr = addr; v.wr = wr; v.wa = wa; v.wd = wd; v.bsy = bsy; v.dn = dn;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the sampling point
    task automatic cyc(input logic rst, st, kl, input logic [15:0] base, input logic [7:0] mask);
        @(posedge clk);
        #1;
        reset = rst; start = st; kill = kl; base_addr = base; reg_mask = mask;
        @(negedge clk);
    endtask

    task automatic idle_row();
        add(0,0,0,16'h0,8'h0, 0,16'h0,0,3'd0,16'h0, 0,0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; kill = 1'b0; base_addr = 16'h0; reg_mask = 8'h0;

        // reset state
        idle_row();
        // mask 0000_0101 at 0x0040
        add(0,1,0,16'h0040,8'h05, 0,16'h0000,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0040,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0041,1,3'd0,16'hAAAA, 1,0);
        add(0,0,0,16'h0000,8'h00, 0,16'h0000,1,3'd2,16'hBBBB, 1,1);
        idle_row();
        // empty mask
        add(0,1,0,16'h1234,8'h00, 0,16'h0000,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 0,16'h0000,0,3'd0,16'h0000, 0,1);
        idle_row();
        // start together with kill is dropped
        add(0,1,1,16'h0040,8'h05, 0,16'h0000,0,3'd0,16'h0000, 0,0);
        idle_row();
        // full mask wrapping through 0xFFFF
        add(0,1,0,16'hFFFE,8'hFF, 0,16'h0000,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'hFFFE,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'hFFFF,1,3'd0,16'h3C3D, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0000,1,3'd1,16'h3C3C, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0001,1,3'd2,16'hC3C3, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0002,1,3'd3,16'hC3C2, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0003,1,3'd4,16'hC3C1, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0004,1,3'd5,16'hC3C0, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0005,1,3'd6,16'hC3C7, 1,0);
        add(0,0,0,16'h0000,8'h00, 0,16'h0000,1,3'd7,16'hC3C6, 1,1);
        idle_row();
        // mask F0 killed in cycle 2: only R4 is written, no done
        add(0,1,0,16'h0100,8'hF0, 0,16'h0000,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0100,0,3'd0,16'h0000, 1,0);
        add(0,0,1,16'h0000,8'h00, 1,16'h0101,1,3'd4,16'hC2C3, 1,0);
        idle_row();
        idle_row();
        // reset in cycle 3 of a full-mask run, restart in cycle 5
        add(0,1,0,16'h0200,8'hFF, 0,16'h0000,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0200,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0201,1,3'd0,16'hC1C3, 1,0);
        add(1,0,0,16'h0000,8'h00, 1,16'h0202,1,3'd1,16'hC1C2, 1,0);
        idle_row();
        add(0,1,0,16'h0040,8'h05, 0,16'h0000,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0040,0,3'd0,16'h0000, 1,0);
        add(0,0,0,16'h0000,8'h00, 1,16'h0041,1,3'd0,16'hAAAA, 1,0);
        add(0,0,0,16'h0000,8'h00, 0,16'h0000,1,3'd2,16'hBBBB, 1,1);
        idle_row();

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].st, vecs[i].kl, vecs[i].base, vecs[i].mask);
            chk("mem_rd_en",  i, 32'(mem_rd_en),  32'(vecs[i].rd));
            chk("mem_addr",   i, 32'(mem_addr),   32'(vecs[i].addr));
            chk("rf_wr_en",   i, 32'(rf_wr_en),   32'(vecs[i].wr));
            chk("rf_wr_addr", i, 32'(rf_wr_addr), 32'(vecs[i].wa));
            chk("rf_wr_data", i, 32'(rf_wr_data), 32'(vecs[i].wd));
            chk("busy",       i, 32'(busy),       32'(vecs[i].bsy));
            chk("done",       i, 32'(done),       32'(vecs[i].dn));
        end

        // start held high while busy is ignored; mask 03 at 0x0010
        cyc(0,1,0,16'h0010,8'h03);
        chk("busy_hold_c0", 0, 32'(busy), 32'd1);
        cyc(0,1,0,16'h9000,8'hFF);
        chk("hold_addr_c1", 1, 32'(mem_addr), 32'h0010);
        cyc(0,1,0,16'h9000,8'hFF);
        chk("hold_addr_c2", 2, 32'(mem_addr), 32'h0011);
        chk("hold_wa_c2",   2, 32'(rf_wr_addr), 32'd0);
        cyc(0,1,0,16'h9000,8'hFF);
        chk("hold_rd_c3",   3, 32'(mem_rd_en), 32'd0);
        chk("hold_done_c3", 3, 32'(done), 32'd1);
        chk("hold_wa_c3",   3, 32'(rf_wr_addr), 32'd1);
        cyc(0,0,0,16'h0000,8'h00);
        chk("hold_busy_c4", 4, 32'(busy), 32'd0);
        chk("hold_rd_c4",   4, 32'(mem_rd_en), 32'd0);

`ifdef LM_SEQ_FWD_EN
        // forwarding copy trails the write port by one cycle
        cyc(0,1,0,16'h0040,8'h05);
        cyc(0,0,0,16'h0000,8'h00);
        cyc(0,0,0,16'h0000,8'h00);
        chk("fwd_valid_c2", 2, 32'(fwd_valid), 32'd0);
        cyc(0,0,0,16'h0000,8'h00);
        chk("fwd_valid_c3", 3, 32'(fwd_valid), 32'd1);
        chk("fwd_reg_c3",   3, 32'(fwd_reg),   32'd0);
        chk("fwd_data_c3",  3, 32'(fwd_data),  32'hAAAA);
        cyc(0,0,0,16'h0000,8'h00);
        chk("fwd_valid_c4", 4, 32'(fwd_valid), 32'd1);
        chk("fwd_reg_c4",   4, 32'(fwd_reg),   32'd2);
        chk("fwd_data_c4",  4, 32'(fwd_data),  32'hBBBB);
        cyc(0,0,0,16'h0000,8'h00);
        chk("fwd_valid_c5", 5, 32'(fwd_valid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
